// File: rtl/jk_ctrl_pkg.sv
// Shared JK operation codes and controller state encodings.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package jk_ctrl_pkg;

    // Operation codes, encoded as {k,j}
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/jk_bank.sv
// Bank of N JK flip-flops, each updated from its own {k,j} pair.
// Latency: q reflects j/k one clock after they are presented.
// Backpressure: none; j=k=0 holds a bit, so idle cycles leave the bank untouched.
module jk_bank
    import jk_ctrl_pkg::*;
#(
    parameter int            N    = 4,
    parameter logic [N-1:0]  INIT = {N{1'b1}}
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] j_i,
    input  logic [N-1:0] k_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] bank_q;

    // Per-bit JK update; reset restores the power-up pattern
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_q <= INIT;
        end else begin
            for (int i = 0; i < N; i++) begin
                case ({k_i[i], j_i[i]})
                    OP_SET:    bank_q[i] <= 1'b1;
                    OP_RESET:  bank_q[i] <= 1'b0;
                    OP_TOGGLE: bank_q[i] <= ~bank_q[i];
                    default:   bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    assign q_o = bank_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK bank between two masked-op requesters.
// Latency: req sampled at edge T, bank updates at T+1, ack pulses in the cycle after T+1.
// Backpressure: requesters hold req until their ack; one op is serviced every 3 cycles.
module jk_bank_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int            N    = 4,
    parameter logic [N-1:0]  INIT = {N{1'b1}}
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [1:0]   req,
    input  logic [1:0]   op0,
    input  logic [N-1:0] mask0,
    input  logic [1:0]   op1,
    input  logic [N-1:0] mask1,
    output logic [1:0]   ack,
    output logic         busy,
    output logic [N-1:0] q
);

    state_t       state_q, state_d;
    logic         ptr_q,   ptr_d;
    logic         win_q,   win_d;
    logic [1:0]   op_q,    op_d;
    logic [N-1:0] mask_q,  mask_d;

    logic         grant_id;
    logic [N-1:0] bank_j;
    logic [N-1:0] bank_k;

    // A lone requester always wins; on a tie the pointer decides
    assign grant_id = (req == 2'b11) ? ptr_q : req[1];

    // Controller state, pointer and latched command registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            op_q    <= OP_HOLD;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state: grant in IDLE, then a fixed apply/complete sequence
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d   = grant_id;
                    op_d    = grant_id ? op1   : op0;
                    mask_d  = grant_id ? mask1 : mask0;
                    ptr_d   = ~grant_id;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bank is driven only during EXEC so each grant yields exactly one update
    assign bank_j = (state_q == EXEC) ? (mask_q & {N{op_q[0]}}) : '0;
    assign bank_k = (state_q == EXEC) ? (mask_q & {N{op_q[1]}}) : '0;

    assign ack  = (state_q == DONE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy = (state_q != IDLE);

    jk_bank #(
        .N    (N),
        .INIT (INIT)
    ) u_bank (
        .clock   (clock),
        .reset_n (reset_n),
        .j_i     (bank_j),
        .k_i     (bank_k),
        .q_o     (q)
    );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: directed ops push expected acks, a monitor checks them.
// Latency: expected ack two edges after the sampling edge (plus three more for a queued loser).
// Backpressure: driver holds each req until its ack is seen, then drops it.
module tb_jk_bank_arbiter;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [1:0]   req;
    logic [1:0]   op0;
    logic [N-1:0] mask0;
    logic [1:0]   op1;
    logic [N-1:0] mask1;
    logic [1:0]   ack;
    logic         busy;
    logic [N-1:0] q;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [1:0]   ack;
        logic [N-1:0] q;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    jk_bank_arbiter #(
        .N    (N),
        .INIT (4'b1111)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .op0     (op0),
        .mask0   (mask0),
        .op1     (op1),
        .mask1   (mask1),
        .ack     (ack),
        .busy    (busy),
        .q       (q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pulse must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clock);
            if (ack !== 2'b00) begin
                check("ack_onehot", {31'b0, (ack == 2'b11)}, 32'd0);
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_ack: got ack=%b with nothing outstanding, expected 00", ack);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_value", {30'b0, ack}, {30'b0, mon_e.ack});
                    check("q_at_ack", {28'b0, q}, {28'b0, mon_e.q});
                    check("ack_cycle", cyc, mon_e.cyc);
                    check("busy_at_ack", {31'b0, busy}, 32'd1);
                end
            end
        end
    end

    // Raise req, record expectations, and drop each req bit when its ack appears
    task automatic issue(input logic [1:0] r,
                         input logic [1:0] o0, input logic [N-1:0] m0,
                         input logic [1:0] o1, input logic [N-1:0] m1,
                         input logic [1:0] a1, input logic [N-1:0] q1,
                         input logic [1:0] a2, input logic [N-1:0] q2);
        int   base;
        int   n;
        exp_t e;
        @(negedge clock);
        base  = cyc;
        op0   = o0;
        mask0 = m0;
        op1   = o1;
        mask1 = m1;
        req   = r;
        e.ack = a1; e.q = q1; e.cyc = base + 2;
        sb.push_back(e);
        if (a2 != 2'b00) begin
            e.ack = a2; e.q = q2; e.cyc = base + 5;
            sb.push_back(e);
        end
        n = 0;
        while (req != 2'b00 && n < 20) begin
            @(negedge clock);
            n++;
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
        end
        if (req != 2'b00) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout: req still %b after 20 cycles, expected all acked", req);
            req = 2'b00;
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = 2'b00;
        op0     = 2'b00;
        mask0   = '0;
        op1     = 2'b00;
        mask1   = '0;
        repeat (2) @(negedge clock);
        check("reset_q",    {28'b0, q},    32'hF);
        check("reset_ack",  {30'b0, ack},  32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;

        // Single request: reset bits 0 and 2 -> 1010
        issue(2'b01, 2'b10, 4'b0101, 2'b00, 4'b0000, 2'b01, 4'b1010, 2'b00, 4'b0000);
        // Hold on all bits from requester 0 while pointer favours requester 1
        issue(2'b01, 2'b00, 4'b1111, 2'b00, 4'b0000, 2'b01, 4'b1010, 2'b00, 4'b0000);
        // Full toggle from requester 1
        issue(2'b10, 2'b00, 4'b0000, 2'b11, 4'b1111, 2'b10, 4'b0101, 2'b00, 4'b0000);
        // Clear the bank via requester 1 (pointer stays at 0)
        issue(2'b10, 2'b00, 4'b0000, 2'b10, 4'b1111, 2'b10, 4'b0000, 2'b00, 4'b0000);
        // Contention, pointer 0: requester 0 sets 0011, then requester 1 toggles 0110
        issue(2'b11, 2'b01, 4'b0011, 2'b11, 4'b0110, 2'b01, 4'b0011, 2'b10, 4'b0101);
        // Contention again: order reveals pointer returned to 0
        issue(2'b11, 2'b10, 4'b1000, 2'b01, 4'b1000, 2'b01, 4'b0101, 2'b10, 4'b1101);
        // Clear via requester 1
        issue(2'b10, 2'b00, 4'b0000, 2'b10, 4'b1111, 2'b10, 4'b0000, 2'b00, 4'b0000);

        // Reset in the middle of an EXEC phase: no ack, bank back to all ones
        @(negedge clock);
        op0   = 2'b01;
        mask0 = 4'b0000;
        req   = 2'b01;
        @(posedge clock);
        #2;
        check("busy_in_exec", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("midop_reset_q",    {28'b0, q},    32'hF);
        check("midop_reset_ack",  {30'b0, ack},  32'h0);
        check("midop_reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clock);
        req     = 2'b00;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("after_reset_q", {28'b0, q}, 32'hF);

        // Pointer was cleared by reset: requester 0 goes first
        issue(2'b11, 2'b10, 4'b0001, 2'b11, 4'b1000, 2'b01, 4'b1110, 2'b10, 4'b0110);
        // Toggle with empty mask changes nothing but still acks
        issue(2'b01, 2'b11, 4'b0000, 2'b00, 4'b0000, 2'b01, 4'b0110, 2'b00, 4'b0000);

        repeat (4) @(negedge clock);
        check("scoreboard_empty", sb.size(), 32'd0);
        check("final_busy", {31'b0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of N JK flip-flops between two requesters.
- Each requester issues a JK operation (hold/set/reset/toggle) with a per-bit mask through a req/ack handshake.
- The block arbitrates round-robin, sequences the bank through apply and complete phases, and exposes the bank state.
- It sits between software-like command sources and the JK register bank, replacing per-bit hand-driven j/k wiring.

Parameters:
- N, 4, number of JK flip-flops in the bank.
- INIT, {N{1'b1}}, bank value loaded on reset (all ones, matching the power-up value of the existing JK flip-flops).

Ports:
- clock  input  1  single system clock, all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  2  req[i]=1 requests service for requester i; held until ack[i] is seen.
- op0  input  2  requester 0 operation, encoded {k,j}.
- mask0  input  N  requester 0 bit select; 1 = bit takes op0, 0 = bit holds.
- op1  input  2  requester 1 operation, encoded {k,j}.
- mask1  input  N  requester 1 bit select.
- ack  output  2  one-cycle completion pulse for requester i.
- busy  output  1  high whenever state is not IDLE.
- q  output  N  current bank contents.

Behaviour:
- Reset (reset_n low, async, takes effect immediately):
  - state=IDLE, q=INIT, ack=2'b00, busy=0, priority pointer=0, latched op/mask cleared.
  - Any in-flight operation is discarded with no ack.
- Op encoding {k,j}:
  - 00 hold: q unchanged.
  - 01 set: q=1.
  - 10 reset: q=0.
  - 11 toggle: q=~q.
  - Applied per bit only where mask=1; mask=0 bits get j=k=0.
- State machine (3 states):
  - IDLE: at posedge, if any req is high, select winner, latch its op and mask, record the winner id, go to EXEC. Otherwise stay in IDLE.
  - EXEC: drive the internal j/k vectors from the latched op and mask. At posedge the bank updates and state goes to DONE.
  - DONE: ack[winner]=1 for exactly this cycle; q already holds the new value. At posedge go to IDLE. The priority pointer moves to the non-winner.
- Latency and throughput:
  - A request is sampled at posedge T.
  - q changes at T+1; ack is high during cycle T+2.
  - Throughput is one operation per 3 cycles.
- Handshake:
  - req is sampled only in IDLE; op and mask must be stable at that sampling edge.
  - Requesters drop req at the edge that ends their ack cycle.
  - A req still high in IDLE is treated as a new request.
  - req changes during EXEC/DONE are ignored.
- Arbitration:
  - A single req wins regardless of the pointer.
  - With both high, the requester named by the pointer wins. The other is served next, in its own later IDLE.
  - The pointer updates only on a grant.
- Boundaries:
  - mask=0 or op=00 still runs the full 3-cycle sequence and acks, with q unchanged.
  - Toggle with mask all ones inverts every bit.
  - ack never has both bits set.
  - At most one bank update occurs per granted request.
- No combinational path from req/op/mask to q or ack.

Decomposition:
- Shared package jk_ctrl_pkg holds:
  - op constants OP_HOLD=2'b00, OP_SET=2'b01, OP_RESET=2'b10, OP_TOGGLE=2'b11.
  - state encodings IDLE, EXEC, DONE.
- One sub-module, jk_bank: N JK flip-flops with a per-bit {k,j} case update on posedge clock, async active-low reset to INIT.
- The arbiter, FSM and op/mask latches stay in jk_bank_arbiter.

Test Plan (N=4, INIT=4'b1111):
- Reset: pulse reset_n low mid-cycle -> q=1111 immediately, ack=00, busy=0.
- Single request: req=01, op0=10, mask0=0101 sampled at edge T -> q=1010 after T+1, ack=01 during cycle T+2 only, busy high T..T+2.
- Toggle: req=10, op1=11, mask1=1111 from q=1010 -> q=0101, ack=10 one cycle.
- Contention:
  - Starting from q=0000 with pointer=0, raise both req: req0 op0=01 mask0=0011, req1 op1=11 mask1=0110.
  - Requester 0 is served first: q=0011, ack=01.
  - Requester 1 is served next: q=0101, ack=10.
  - Pointer ends at 0.
- Reset mid-operation: assert reset_n=0 while in EXEC of a set with mask 0000 applied over q=0000 -> q=1111, no ack pulse, next contention grants requester 0.
- No-op: op0=00, mask0=1111, then op0=11, mask0=0000 -> q unchanged both times, each acked exactly 2 cycles after sampling.
